// File: rtl/keypad_entry.sv
// ============================================================================
// Module  : keypad_entry
// Brief   : Assembles hex keypresses into a held code word with submit strobe.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module keypad_entry #(
   parameter int DIGITS         = 8,
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int CNT_W          = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  key_valid,
   input  logic [3:0]            key_code,
   input  logic                  key_enter,
   input  logic                  key_clear,
   output logic [4*DIGITS-1:0]   code,
   output logic                  code_valid,
   output logic [3:0]            digit_count,
   output logic                  entry_active,
   output logic                  short_err,
   output logic                  overflow,
   output logic                  timeout
);

   localparam int            C_W     = 4*DIGITS;
   localparam logic [3:0]    C_LAST  = 4'(DIGITS-1);
   localparam logic [CNT_W-1:0] C_TMAX = CNT_W'(TIMEOUT_CYCLES-1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ENTRY  = 2'd1,
      FULL   = 2'd2,
      SUBMIT = 2'd3
   } state_t;

   state_t             r_state;
   logic [C_W-1:0]     r_shift;
   logic [3:0]         r_count;
   logic [CNT_W-1:0]   r_tcnt;

   assign digit_count  = r_count;
   assign entry_active = (r_count != 4'd0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= IDLE;
         r_shift    <= '0;
         r_count    <= 4'd0;
         r_tcnt     <= '0;
         code       <= '0;
         code_valid <= 1'b0;
         short_err  <= 1'b0;
         overflow   <= 1'b0;
         timeout    <= 1'b0;
      end else begin
         code_valid <= 1'b0;
         short_err  <= 1'b0;
         overflow   <= 1'b0;
         timeout    <= 1'b0;
         case (r_state)
            SUBMIT: begin
               // Strobe follows the code update by one cycle; only a digit starts a new entry.
               code_valid <= 1'b1;
               r_tcnt     <= '0;
               if (!key_clear && !key_enter && key_valid) begin
                  r_shift <= {r_shift[C_W-5:0], key_code};
                  r_count <= 4'd1;
                  r_state <= ENTRY;
               end else begin
                  r_state <= IDLE;
               end
            end
            default: begin
               if (key_clear) begin
                  r_shift <= '0;
                  r_count <= 4'd0;
                  r_tcnt  <= '0;
                  r_state <= IDLE;
               end else if (key_enter) begin
                  if (r_state == FULL) begin
                     code    <= r_shift;
                     r_shift <= '0;
                     r_count <= 4'd0;
                     r_tcnt  <= '0;
                     r_state <= SUBMIT;
                  end else if (r_state == ENTRY) begin
                     short_err <= 1'b1;
                     r_shift   <= '0;
                     r_count   <= 4'd0;
                     r_tcnt    <= '0;
                     r_state   <= IDLE;
                  end
               end else if (key_valid) begin
                  r_tcnt <= '0;
                  if (r_state == FULL) begin
                     overflow <= 1'b1;
                  end else begin
                     r_shift <= {r_shift[C_W-5:0], key_code};
                     r_count <= r_count + 4'd1;
                     r_state <= (r_count == C_LAST) ? FULL : ENTRY;
                  end
               end else if (r_state != IDLE) begin
                  if (r_tcnt == C_TMAX) begin
                     timeout <= 1'b1;
                     r_shift <= '0;
                     r_count <= 4'd0;
                     r_tcnt  <= '0;
                     r_state <= IDLE;
                  end else begin
                     r_tcnt <= r_tcnt + 1'b1;
                  end
               end
            end
         endcase
      end
   end

endmodule

`default_nettype wire
